// File: rtl/dct_pkg.sv
// Shared types and defaults for the IntDCT first butterfly stage.
package dct_pkg;

    localparam int DCT_IN_WIDTH = 16;
    localparam int DCT_DIM      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        CALC = 2'd2,
        OUT  = 2'd3
    } bfly_state_t;

    // Width of a row sample index; never narrower than one bit.
    function automatic int idx_width(input int dim);
        return (dim <= 2) ? 1 : $clog2(dim);
    endfunction

endpackage

// File: rtl/dct_bfly_seq_inputaddunit.sv
// Butterfly input add unit: pairs x[i] with its mirror x[DIM-1-i].
// Sums are sign-extended by one bit and exact; differences keep IN_WIDTH
// bits, so they wrap on overflow (the low bits match a widened subtract).
module inputaddunit #(
    parameter int IN_WIDTH = 16,
    parameter int DIM      = 8
) (
    input  logic [DIM-1:0][IN_WIDTH-1:0]   x_i,
    output logic [DIM/2-1:0][IN_WIDTH:0]   sum_o,
    output logic [DIM/2-1:0][IN_WIDTH-1:0] diff_o
);

    for (genvar i = 0; i < DIM / 2; i++) begin : g_lane
        logic [IN_WIDTH:0] a_ext;
        logic [IN_WIDTH:0] b_ext;

        assign a_ext     = {x_i[i][IN_WIDTH-1], x_i[i]};
        assign b_ext     = {x_i[DIM-1-i][IN_WIDTH-1], x_i[DIM-1-i]};
        assign sum_o[i]  = a_ext + b_ext;
        assign diff_o[i] = x_i[i] - x_i[DIM-1-i];
    end

endmodule

// File: rtl/dct_bfly_seq.sv
// Row collector and sequencer for the first IntDCT butterfly stage.
// Optional macro DCT_BFLY_PINGPONG_EN: two row buffers so the next row is
// collected while a result waits for the consumer.
//
// state | meaning
// IDLE  | no partial row, waiting for sample 0
// FILL  | collecting samples 1..DIM-1
// CALC  | one cycle, butterfly result captured at the end of it
// OUT   | result presented, waiting for out_ready
module dct_bfly_seq
    import dct_pkg::*;
#(
    parameter int IN_WIDTH = DCT_IN_WIDTH,
    parameter int DIM      = DCT_DIM
) (
    input  logic                            HCLK,
    input  logic                            HRESETn,
    input  logic [IN_WIDTH-1:0]             in_data,
    input  logic                            in_valid,
    input  logic                            in_first,
    output logic                            in_ready,
    output logic [DIM/2-1:0][IN_WIDTH:0]    out_sum,
    output logic [DIM/2-1:0][IN_WIDTH-1:0]  out_diff,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            sync_err,
    output logic                            busy
);

    localparam int               IDX_W    = idx_width(DIM);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIM - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    if (DIM < 2 || (DIM % 2) != 0) begin : g_dim_check
        $error("dct_bfly_seq: DIM must be even and at least 2");
    end

    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [DIM/2-1:0][IN_WIDTH:0]    sum_q, sum_d;
    logic [DIM/2-1:0][IN_WIDTH-1:0]  diff_q, diff_d;
    logic                            out_valid_q, out_valid_d;
    logic                            sync_err_q, sync_err_d;
    logic                            in_ready_c;
    bfly_state_t                     state_c;

    logic [DIM-1:0][IN_WIDTH-1:0]    bfly_x;
    logic [DIM/2-1:0][IN_WIDTH:0]    bfly_sum;
    logic [DIM/2-1:0][IN_WIDTH-1:0]  bfly_diff;

    inputaddunit #(
        .IN_WIDTH (IN_WIDTH),
        .DIM      (DIM)
    ) u_bfly (
        .x_i    (bfly_x),
        .sum_o  (bfly_sum),
        .diff_o (bfly_diff)
    );

    // Registers shared by both buffer arrangements.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            idx_q       <= '0;
            sum_q       <= '0;
            diff_q      <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            diff_q      <= diff_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
        end
    end

`ifdef DCT_BFLY_PINGPONG_EN
    logic [1:0][DIM-1:0][IN_WIDTH-1:0] bank_q, bank_d;
    logic [1:0]                        full_q, full_d;
    logic                              wr_sel_q, wr_sel_d;
    logic                              rd_sel_q, rd_sel_d;
    logic                              calc_c;

    // The oldest full bank is computed as soon as the output register is free.
    assign in_ready_c = !full_q[wr_sel_q];
    assign calc_c     = full_q[rd_sel_q] && !out_valid_q;
    assign bfly_x     = bank_q[rd_sel_q];

    // Bank storage and fill/read pointers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            bank_q   <= '0;
            full_q   <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            bank_q   <= bank_d;
            full_q   <= full_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    // Fill side and output side run independently; they touch different banks.
    always_comb begin
        bank_d      = bank_q;
        full_d      = full_q;
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        diff_d      = diff_q;
        out_valid_d = out_valid_q;
        sync_err_d  = 1'b0;
        if (in_valid && in_ready_c) begin
            if (in_first && idx_q != '0) begin
                bank_d[wr_sel_q][0] = in_data;
                idx_d               = IDX_ONE;
                sync_err_d          = 1'b1;
            end else begin
                bank_d[wr_sel_q][idx_q] = in_data;
                if (idx_q == IDX_LAST) begin
                    idx_d            = '0;
                    full_d[wr_sel_q] = 1'b1;
                    wr_sel_d         = !wr_sel_q;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
        end
        if (calc_c) begin
            sum_d       = bfly_sum;
            diff_d      = bfly_diff;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d      = 1'b0;
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = !rd_sel_q;
        end
    end

    // Reported state is derived: output side takes priority over fill side.
    always_comb begin
        state_c = IDLE;
        if (out_valid_q)                      state_c = OUT;
        else if (calc_c)                      state_c = CALC;
        else if (idx_q != '0 || full_q != '0) state_c = FILL;
    end
`else
    bfly_state_t                  state_q, state_d;
    logic [DIM-1:0][IN_WIDTH-1:0] buf_q, buf_d;

    assign bfly_x  = buf_q;
    assign state_c = state_q;

    // State register and row buffer.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
        end
    end

    // Next-state, buffer writes and result capture.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        diff_d      = diff_q;
        out_valid_d = out_valid_q;
        sync_err_d  = 1'b0;
        in_ready_c  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (in_valid) begin
                    buf_d[0] = in_data;
                    idx_d    = IDX_ONE;
                    state_d  = FILL;
                end
            end
            FILL: begin
                in_ready_c = 1'b1;
                if (in_valid) begin
                    if (in_first && idx_q != '0) begin
                        buf_d[0]   = in_data;
                        idx_d      = IDX_ONE;
                        sync_err_d = 1'b1;
                    end else begin
                        buf_d[idx_q] = in_data;
                        if (idx_q == IDX_LAST) begin
                            idx_d   = '0;
                            state_d = CALC;
                        end else begin
                            idx_d = idx_q + IDX_ONE;
                        end
                    end
                end
            end
            CALC: begin
                sum_d       = bfly_sum;
                diff_d      = bfly_diff;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
`endif

    assign in_ready  = in_ready_c;
    assign out_sum   = sum_q;
    assign out_diff  = diff_q;
    assign out_valid = out_valid_q;
    assign sync_err  = sync_err_q;
    assign busy      = (state_c != IDLE);

endmodule

// File: tb/tb_dct_bfly_seq.sv
// Bench for dct_bfly_seq: random rows against an arithmetic reference.
module tb_dct_bfly_seq;

    localparam int W = 16;
    localparam int D = 8;
    localparam int H = D / 2;
`ifdef DCT_BFLY_PINGPONG_EN
    localparam int ROW_PERIOD = D;
`else
    localparam int ROW_PERIOD = D + 2;
`endif

    logic                 clk = 1'b0;
    logic                 HRESETn = 1'b0;
    logic [W-1:0]         in_data = '0;
    logic                 in_valid = 1'b0;
    logic                 in_first = 1'b0;
    logic                 in_ready;
    logic [H-1:0][W:0]    out_sum;
    logic [H-1:0][W-1:0]  out_diff;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic                 sync_err;
    logic                 busy;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int sync_seen = 0;

    dct_bfly_seq #(.IN_WIDTH(W), .DIM(D)) dut (
        .HCLK      (clk),
        .HRESETn   (HRESETn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_ready  (in_ready),
        .out_sum   (out_sum),
        .out_diff  (out_diff),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sync_err  (sync_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (sync_err === 1'b1) sync_seen++;

    // Reference: mirror-pair sum (exact) and difference (wrapped to W bits).
    function automatic void model(input int x[D], output logic [H-1:0][W:0] s,
                                  output logic [H-1:0][W-1:0] d);
        for (int i = 0; i < H; i++) begin
            s[i] = (W+1)'(x[i] + x[D-1-i]);
            d[i] = W'(x[i] - x[D-1-i]);
        end
    endfunction

    function automatic int rnd_sample();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    task automatic push(input int v, input bit first, output int waited);
        waited = 0;
        in_data = W'(v);
        in_first = first;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            n_cmp++; n_fail++;
            $display("FAIL push_timeout: in_ready=%b, required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic push_row(input int x[D], input bit first, output int waited);
        int w;
        waited = 0;
        for (int i = 0; i < D; i++) begin
            push(x[i], first && (i == 0), w);
            waited += w;
        end
    endtask

    task automatic wait_result(input int budget, output bit ok);
        int n = 0;
        while (out_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (out_valid === 1'b1);
    endtask

    task automatic test_reset();
        int x[D];
        int w;
        logic [H-1:0][W:0]   es;
        logic [H-1:0][W-1:0] ed;
        HRESETn = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        n_cmp++; if ({out_valid, busy, sync_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: valid/busy/sync got %b, required 000", {out_valid, busy, sync_err}); end
        n_cmp++; if (out_sum !== '0 || out_diff !== '0) begin n_fail++; $display("FAIL reset_data: sum %h diff %h, required 0", out_sum, out_diff); end
        HRESETn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < D; i++) x[i] = i + 1;
        model(x, es, ed);
        push_row(x, 1'b0, w);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early: out_valid %b at last accept, required 0", out_valid); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL latency: out_valid %b one cycle after last accept, required 1", out_valid); end
        n_cmp++; if (out_sum !== es) begin n_fail++; $display("FAIL ramp_sum: got %h, required %h", out_sum, es); end
        n_cmp++; if (out_diff !== ed) begin n_fail++; $display("FAIL ramp_diff: got %h, required %h", out_diff, ed); end
        n_cmp++; if (out_sum[0] !== 17'd9 || out_diff[0] !== 16'hFFF9) begin n_fail++; $display("FAIL ramp_lane0: sum %h diff %h, required 00009 fff9", out_sum[0], out_diff[0]); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ramp_handshake: valid %b busy %b, required 0 0", out_valid, busy); end
    endtask

    task automatic test_overflow();
        int x[D];
        int w;
        bit ok;
        logic [H-1:0][W:0]   es;
        logic [H-1:0][W-1:0] ed;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < D; i++) x[i] = 0;
            x[0] = 32767;
            x[D-1] = (p == 0) ? -32768 : 32767;
            model(x, es, ed);
            push_row(x, 1'b0, w);
            wait_result(5, ok);
            n_cmp++; if (!ok) begin n_fail++; $display("FAIL ovf_valid[%0d]: out_valid %b, required 1", p, out_valid); end
            n_cmp++; if (out_sum !== es || out_diff !== ed) begin n_fail++; $display("FAIL ovf_data[%0d]: sum %h diff %h, required %h %h", p, out_sum, out_diff, es, ed); end
            n_cmp++; if (out_sum[0] !== ((p == 0) ? 17'h1FFFF : 17'h0FFFE)) begin n_fail++; $display("FAIL ovf_sum0[%0d]: got %h", p, out_sum[0]); end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int x[D];
        int w;
        bit ok;
        logic [H-1:0][W:0]   es;
        logic [H-1:0][W-1:0] ed;
        out_ready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < D; i++) x[i] = rnd_sample();
            model(x, es, ed);
            push_row(x, ($urandom_range(1) == 1), w);
            wait_result(5, ok);
            n_cmp++; if (!ok) begin n_fail++; $display("FAIL rand_valid[%0d]: out_valid %b, required 1", r, out_valid); end
            n_cmp++; if (out_sum !== es) begin n_fail++; $display("FAIL rand_sum[%0d]: got %h, required %h", r, out_sum, es); end
            n_cmp++; if (out_diff !== ed) begin n_fail++; $display("FAIL rand_diff[%0d]: got %h, required %h", r, out_diff, ed); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int x[D];
        int w;
        bit ok;
        logic [H-1:0][W:0]   es;
        logic [H-1:0][W-1:0] ed;
        out_ready = 1'b0;
        for (int i = 0; i < D; i++) x[i] = rnd_sample();
        model(x, es, ed);
        push_row(x, 1'b0, w);
        wait_result(5, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL bp_valid: out_valid %b, required 1", out_valid); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1 || out_sum !== es || out_diff !== ed) begin n_fail++; $display("FAIL bp_hold[%0d]: valid %b sum %h diff %h, required 1 %h %h", c, out_valid, out_sum, out_diff, es, ed); end
`ifndef DCT_BFLY_PINGPONG_EN
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b, required 0", c, in_ready); end
`endif
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_release: valid %b busy %b, required 0 0", out_valid, busy); end
    endtask

    task automatic test_resync();
        int x[D];
        int w;
        int s0;
        bit ok;
        logic [H-1:0][W:0]   es;
        logic [H-1:0][W-1:0] ed;
        out_ready = 1'b1;
        @(negedge clk);
        s0 = sync_seen;
        for (int i = 0; i < 5; i++) push(rnd_sample(), 1'b0, w);
        for (int i = 0; i < D; i++) x[i] = 10 + i;
        model(x, es, ed);
        push_row(x, 1'b1, w);
        wait_result(5, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL resync_valid: out_valid %b, required 1", out_valid); end
        n_cmp++; if (out_sum !== es || out_diff !== ed) begin n_fail++; $display("FAIL resync_data: sum %h diff %h, required %h %h", out_sum, out_diff, es, ed); end
        n_cmp++; if (out_sum[H-1] !== 17'd27) begin n_fail++; $display("FAIL resync_sum: lane3 %h, required 0001b", out_sum[H-1]); end
        n_cmp++; if (sync_seen - s0 != 1) begin n_fail++; $display("FAIL resync_pulse: %0d pulses, required 1", sync_seen - s0); end
        @(negedge clk);
    endtask

    task automatic test_reset_midrow();
        int x[D];
        int w;
        int seen;
        bit ok;
        logic [H-1:0][W:0]   es;
        logic [H-1:0][W-1:0] ed;
        for (int p = 0; p < 2; p++) begin
            out_ready = (p == 0);
            if (p == 0) begin
                for (int i = 0; i < 4; i++) push(rnd_sample(), 1'b0, w);
            end else begin
                for (int i = 0; i < D; i++) x[i] = rnd_sample();
                push_row(x, 1'b0, w);
                wait_result(5, ok);
                n_cmp++; if (!ok) begin n_fail++; $display("FAIL rstpend_valid: out_valid %b, required 1", out_valid); end
            end
            HRESETn = 1'b0;
            #1;
            n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== '0) begin n_fail++; $display("FAIL rst_clear[%0d]: valid %b busy %b sum %h, required 0 0 0", p, out_valid, busy, out_sum); end
            repeat (2) @(negedge clk);
            HRESETn = 1'b1;
            out_ready = 1'b1;
            seen = 0;
            repeat (12) begin @(negedge clk); if (out_valid === 1'b1) seen++; end
            n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL rst_noout[%0d]: %0d valid cycles, required 0", p, seen); end
            for (int i = 0; i < D; i++) x[i] = rnd_sample();
            model(x, es, ed);
            push_row(x, 1'b0, w);
            wait_result(5, ok);
            n_cmp++; if (!ok || out_sum !== es || out_diff !== ed) begin n_fail++; $display("FAIL rst_next[%0d]: valid %b sum %h diff %h, required 1 %h %h", p, out_valid, out_sum, out_diff, es, ed); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int rows[3][D];
        int t[3];
        int got;
        int stalls;
        logic [H-1:0][W:0]   gs[3];
        logic [H-1:0][W-1:0] gd[3];
        logic [H-1:0][W:0]   es;
        logic [H-1:0][W-1:0] ed;
        out_ready = 1'b1;
        for (int r = 0; r < 3; r++) for (int i = 0; i < D; i++) rows[r][i] = rnd_sample();
        got = 0;
        stalls = 0;
        @(negedge clk);
        fork
            begin
                int xr[D];
                int w;
                for (int r = 0; r < 3; r++) begin
                    for (int i = 0; i < D; i++) xr[i] = rows[r][i];
                    push_row(xr, 1'b0, w);
                    stalls += w;
                end
            end
            begin
                int n = 0;
                while (got < 3 && n < 200) begin
                    @(negedge clk);
                    n++;
                    if (out_valid === 1'b1 && out_ready === 1'b1) begin
                        t[got] = cyc; gs[got] = out_sum; gd[got] = out_diff;
                        got++;
                    end
                end
            end
        join
        n_cmp++; if (got != 3) begin n_fail++; $display("FAIL b2b_count: %0d results, required 3", got); end
        for (int r = 0; r < got; r++) begin
            int xr[D];
            for (int i = 0; i < D; i++) xr[i] = rows[r][i];
            model(xr, es, ed);
            n_cmp++; if (gs[r] !== es || gd[r] !== ed) begin n_fail++; $display("FAIL b2b_row[%0d]: sum %h diff %h, required %h %h", r, gs[r], gd[r], es, ed); end
            if (r > 0) begin
                n_cmp++; if (t[r] - t[r-1] != ROW_PERIOD) begin n_fail++; $display("FAIL b2b_period[%0d]: %0d cycles, required %0d", r, t[r] - t[r-1], ROW_PERIOD); end
            end
        end
`ifdef DCT_BFLY_PINGPONG_EN
        n_cmp++; if (stalls != 0) begin n_fail++; $display("FAIL b2b_stall: in_ready low for %0d cycles, required 0", stalls); end
`endif
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_random();
        test_backpressure();
        test_resync();
        test_reset_midrow();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dct_bfly_seq.md
Name: dct_bfly_seq

Overview:
- Sequencer for the IntDCT first butterfly stage.
- Accepts one signed sample per cycle over a valid/ready stream and collects DIM samples into a row buffer.
- Drives the butterfly input add unit from that buffer and registers its sum and difference vectors.
- Presents the result on a valid/ready output to the next DCT stage, sitting between the AHB-fed sample FIFO and the even/odd DCT kernels.

Parameters:
- IN_WIDTH, 16: sample width, signed two's complement.
- DIM, 8: samples per row. Must be even and at least 2; elaboration error otherwise.

Ports:
- HCLK  in  1  block clock.
- HRESETn  in  1  asynchronous active-low reset.
- in_data  in  IN_WIDTH  signed input sample.
- in_valid  in  1  in_data is valid.
- in_first  in  1  marks sample 0 of a row; sampled only when in_valid is high.
- in_ready  out  1  block can accept a sample this cycle.
- out_sum  out  (DIM/2)x(IN_WIDTH+1)  registered sums; out_sum[i] = x[i] + x[DIM-1-i].
- out_diff  out  (DIM/2)xIN_WIDTH  registered differences; out_diff[i] = x[i] - x[DIM-1-i], wrapped to IN_WIDTH bits.
- out_valid  out  1  result vector is valid.
- out_ready  in  1  consumer accepts the vector.
- sync_err  out  1  one-cycle pulse on a row resync.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values (async, HRESETn low): state IDLE, sample index 0, buffer 0, out_sum/out_diff 0, out_valid 0, sync_err 0, busy 0. in_ready is 1 after reset.
- Accept: a sample is accepted on a rising edge where in_valid && in_ready. Samples are written to buf[idx], then idx increments.
- States:
  - IDLE: in_ready=1. First accept writes buf[0], idx=1, goes to FILL. in_first is ignored here; sample 0 is implied.
  - FILL: in_ready=1. Accepting index DIM-1 goes to CALC and resets idx to 0.
  - CALC: exactly one cycle, in_ready=0. The butterfly is driven combinationally from buf. out_sum/out_diff are registered at the end of the cycle, out_valid is set, and the FSM goes to OUT.
  - OUT: in_ready=0. Outputs are held stable while out_valid && !out_ready. On out_valid && out_ready, out_valid clears and the FSM goes to IDLE.
- Latency: last sample accepted at edge k → out_valid high after edge k+1. Minimum row period is DIM+2 cycles.
- Arithmetic:
  - Sum is sign-extended to IN_WIDTH+1 bits, so it is exact.
  - Difference is computed at IN_WIDTH+1 bits and truncated to IN_WIDTH bits; wrap is intentional.
- Resync: accept with in_first=1 while in FILL and idx≠0 → the sample is written to buf[0], idx=1, state stays FILL, and sync_err pulses for one cycle. Partial row data is discarded.
- out_ready is ignored when out_valid=0.
- in_valid held high during CALC/OUT is not accepted; data is not lost because in_ready=0.
- Reset asserted mid-row or with out_valid pending: all state clears immediately. The pending row is dropped and no output is produced.
- busy = (state != IDLE).

Optional Feature:
- Macro: DCT_BFLY_PINGPONG_EN.
- Defined:
  - Two row buffers. Fill alternates between them.
  - in_ready stays high in CALC and OUT while the non-output buffer is free, so the next row is collected while the result waits.
  - A buffer is freed on the output handshake.
  - A back-to-back stream with out_ready=1 sustains one sample per cycle; the row period is DIM cycles.
  - in_ready drops only when both buffers are full and out_valid is pending.
  - Row order is strictly preserved.
- Undefined: single buffer, exact behaviour above.

Decomposition:
- Shared package dct_pkg:
  - bfly_state_t enum {IDLE, FILL, CALC, OUT}.
  - Default IN_WIDTH/DIM constants.
  - Function clog2-based index width for DIM.
- Sub-module: instantiate the existing butterfly input add unit (inputaddunit) unchanged for the arithmetic. Sequencing, buffering and registering stay in dct_bfly_seq. No other sub-modules.

Test Plan:
- Reset check: hold HRESETn low → all outputs 0, in_ready=1. Release and stream 1,2,...,8 with out_ready=1 → out_sum={9,9,9,9}, out_diff={-7,-5,-3,-1}, out_valid high exactly 1 cycle after the 8th accept.
- Overflow: stream x0=32767, x7=-32768, rest 0 → out_sum[0]=-1 (17-bit), out_diff[0]=-1 (wrapped 16-bit). Then x0=x7=32767 → out_sum[0]=65534, out_diff[0]=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → outputs stable and in_ready=0 throughout. Release → one handshake, then IDLE.
- Resync: send 5 samples, then in_first=1 with 8 new samples 10..17 → sync_err pulses once; result uses only 10..17 (out_sum all 27).
- Reset mid-row after 4 samples, and separately while out_valid is pending → no output; the next full row produces a correct result.
- PINGPONG_EN: continuous 3-row stream with out_ready=1 → in_ready never drops, 3 results in order, row period 8 cycles.
